// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, digit codes and FSM encoding for the scan controller
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// rtl/seg7_scan_controller_if.sv - value handshake between the output register and the controller
interface seg7_in_if #(parameter int WIDTH = 14);
  logic [WIDTH-1:0] in_value;
  logic             in_valid;
  logic             in_ready;
  logic             done;

  modport master (output in_value, output in_valid, input in_ready, input done);
  modport slave  (input in_value, input in_valid, output in_ready, output done);
endinterface

// File: rtl/bcd.sv
// rtl/bcd.sv - existing decimal digit to active-low {g,f,e,d,c,b,a} segment decoder
module bcd (
  input  logic [4:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      5'd0:    seg_o = 7'b1000000;
      5'd1:    seg_o = 7'b1111001;
      5'd2:    seg_o = 7'b0100100;
      5'd3:    seg_o = 7'b0110000;
      5'd4:    seg_o = 7'b0011001;
      5'd5:    seg_o = 7'b0010010;
      5'd6:    seg_o = 7'b0000010;
      5'd7:    seg_o = 7'b1111000;
      5'd8:    seg_o = 7'b0000000;
      5'd9:    seg_o = 7'b0011000;
      default: seg_o = 7'bxxxxxxx;
    endcase
  end
endmodule

// File: rtl/seg7_scan_controller_dd.sv
// rtl/seg7_scan_controller_dd.sv - one double-dabble iteration: add 3 to nibbles >= 5, then shift left
module double_dabble_step #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] bcd_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [DIGITS*4-1:0] bcd_o,
  output logic [WIDTH-1:0]    bin_o
);
  logic [DIGITS*4-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = adj[k*4 +: 4] + 4'd3;
    end
    bcd_o = {adj[DIGITS*4-2:0], bin_i[WIDTH-1]};
    bin_o = {bin_i[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - binary-to-BCD conversion and multiplexed 7-segment scan
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  seg7_in_if.slave          in_if,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int MAX_VALUE = 10**DIGITS - 1;
  localparam int ITW       = clog2(WIDTH);
  localparam int PW        = clog2(SCAN_DIV);
  localparam int IW        = clog2(DIGITS);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_nx;
  logic [DIGITS*4-1:0] bcd_q, bcd_nx;
  logic [ITW-1:0]      iter_q;
  logic                ovf_q;
  logic                done_q;
  logic [3:0]          digits_q [DIGITS];
  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [6:0]          seg_q, seg_nx, dec_seg;
  logic [DIGITS-1:0]   an_q, lead_zero;
  logic [3:0]          show_code;
  logic [4:0]          dec_in;
  logic                accept, last_iter, zero_run;

  assign accept    = in_if.in_valid && (state_q == ST_IDLE);
  assign last_iter = (state_q == ST_CONV) && (iter_q == ITW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_if.in_valid) state_d = ST_CONV;
      ST_CONV: if (last_iter)      state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_if.in_ready = (state_q == ST_IDLE);
    in_if.done     = done_q;
  end

  double_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
    .bcd_i (bcd_q),
    .bin_i (shift_q),
    .bcd_o (bcd_nx),
    .bin_o (shift_nx)
  );

  // Digit registers are only written on the final iteration so the scan never sees partial BCD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < DIGITS; k++) digits_q[k] <= 4'd0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shift_q <= in_if.in_value;
        bcd_q   <= '0;
        iter_q  <= '0;
        ovf_q   <= (int'(in_if.in_value) > MAX_VALUE);
      end else if (state_q == ST_CONV) begin
        shift_q <= shift_nx;
        bcd_q   <= bcd_nx;
        iter_q  <= iter_q + ITW'(1);
        if (last_iter) begin
          done_q <= 1'b1;
          for (int k = 0; k < DIGITS; k++)
            digits_q[k] <= ovf_q ? CODE_DASH : bcd_nx[k*4 +: 4];
        end
      end
    end
  end

  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run && (digits_q[k] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  // Blank and dash bypass the shared decoder so it only ever sees 0-9.
  always_comb begin
    show_code = digits_q[idx_q];
    if ((LZ_BLANK != 0) && lead_zero[idx_q]) show_code = CODE_BLANK;
    dec_in = (show_code <= 4'd9) ? {1'b0, show_code} : 5'd0;
  end

  bcd u_bcd (
    .bcd_i (dec_in),
    .seg_o (dec_seg)
  );

  always_comb begin
    if (show_code <= 4'd9)           seg_nx = dec_seg;
    else if (show_code == CODE_DASH) seg_nx = SEG_DASH;
    else                             seg_nx = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      seg_q <= seg_nx;
      an_q  <= ~(DIGITS'(1) << idx_q);
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - randomized self-checking bench against a decimal display model
module tb_seg7_scan_controller;
  localparam int WIDTH    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [6:0]        seg_a, seg_b;
  logic [DIGITS-1:0] an_a, an_b;
  int                checks = 0;
  int                errors = 0;
  logic [6:0]        glyphs [10];

  seg7_in_if #(.WIDTH(WIDTH)) a_if ();
  seg7_in_if #(.WIDTH(WIDTH)) b_if ();

  seg7_scan_controller #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .LZ_BLANK(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .in_if   (a_if),
    .seg     (seg_a),
    .an      (an_a)
  );

  seg7_scan_controller #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .LZ_BLANK(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .in_if   (b_if),
    .seg     (seg_b),
    .an      (an_b)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int v, input int k, input bit lz);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) return 7'b0111111;
    if (lz && k > 0 && v < p) return 7'b1111111;
    return glyphs[(v / p) % 10];
  endfunction

  function automatic bit rdy(input bit sel);
    return sel ? b_if.in_ready : a_if.in_ready;
  endfunction

  function automatic bit dn(input bit sel);
    return sel ? b_if.done : a_if.done;
  endfunction

  function automatic logic [6:0] segv(input bit sel);
    return sel ? seg_b : seg_a;
  endfunction

  function automatic int an_index(input bit sel);
    logic [DIGITS-1:0] a, onehot;
    a = sel ? an_b : an_a;
    for (int k = 0; k < DIGITS; k++) begin
      onehot = ~(DIGITS'(1) << k);
      if (a === onehot) return k;
    end
    return -1;
  endfunction

  task automatic drive(input bit sel, input int v, input bit valid);
    if (sel) begin
      b_if.in_value = WIDTH'(v);
      b_if.in_valid = valid;
    end else begin
      a_if.in_value = WIDTH'(v);
      a_if.in_valid = valid;
    end
  endtask

  task automatic wait_ready(input bit sel);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy(sel) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Returns cycles with in_ready low and whether done pulsed exactly when in_ready came back.
  task automatic convert(input int v, input bit sel, output int busy, output bit done_ok);
    bit early;
    busy  = 0;
    early = 1'b0;
    wait_ready(sel);
    drive(sel, v, 1'b1);
    @(negedge clk);
    drive(sel, 0, 1'b0);
    while (!rdy(sel) && busy < 100) begin
      if (dn(sel)) early = 1'b1;
      busy++;
      @(negedge clk);
    end
    done_ok = dn(sel) && !early;
  endtask

  task automatic check_display(input int v, input bit sel, input string name);
    bit [DIGITS-1:0] seen;
    logic [6:0]      got [DIGITS];
    int              guard, k;
    seen  = '0;
    guard = 0;
    for (int d = 0; d < DIGITS; d++) got[d] = 7'h00;
    while (seen != '1 && guard < 64) begin
      @(negedge clk);
      guard++;
      k = an_index(sel);
      if (k >= 0) begin
        got[k]  = segv(sel);
        seen[k] = 1'b1;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      checks++;
      if (!seen[d]) begin
        errors++;
        $display("FAIL %s digit%0d never scanned (value %0d)", name, d, v);
      end else if (got[d] !== exp_seg(v, d, !sel)) begin
        errors++;
        $display("FAIL %s digit%0d value %0d seg %b expected %b", name, d, v, got[d], exp_seg(v, d, !sel));
      end
    end
  endtask

  task automatic check_conv(input int v, input bit sel, input string name);
    int busy;
    bit dok;
    convert(v, sel, busy, dok);
    checks++;
    if (busy !== 14) begin
      errors++;
      $display("FAIL %s busy cycles %0d expected 14", name, busy);
    end
    checks++;
    if (dok !== 1'b1) begin
      errors++;
      $display("FAIL %s done pulse %0b expected 1", name, dok);
    end
    check_display(v, sel, name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (seg_a !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b expected 1111111", seg_a); end
    checks++;
    if (an_a !== 4'b1111) begin errors++; $display("FAIL reset_an got %b expected 1111", an_a); end
    checks++;
    if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", a_if.in_ready); end
    checks++;
    if (a_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", a_if.done); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (an_a !== 4'b1110) begin errors++; $display("FAIL first_edge_an got %b expected 1110", an_a); end
    checks++;
    if (seg_a !== 7'b1000000) begin errors++; $display("FAIL first_edge_seg got %b expected 1000000", seg_a); end
    check_display(0, 0, "reset_display");
  endtask

  task automatic test_conversion();
    check_conv(1234, 0, "conv_1234");
  endtask

  task automatic test_leading_zeros();
    check_conv(7, 0, "lz_7");
    check_conv(0, 0, "lz_0");
    check_conv(7, 1, "nolz_7");
  endtask

  task automatic test_boundary();
    check_conv(9999, 0, "max_9999");
    check_conv(10000, 0, "ovf_10000");
    check_conv(16383, 0, "ovf_16383");
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 16383));
      check_conv(v, i[0], "random");
    end
  endtask

  task automatic test_back_to_back();
    int busy, bad, k;
    wait_ready(0);
    drive(0, 5678, 1'b1);
    @(negedge clk);
    drive(0, 42, 1'b1);
    busy = 0;
    while (!a_if.in_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 14) begin errors++; $display("FAIL b2b_first_busy got %0d expected 14", busy); end
    checks++;
    if (a_if.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b expected 1", a_if.done); end
    @(negedge clk);
    drive(0, 0, 1'b0);
    busy = 0;
    bad  = 0;
    while (!a_if.in_ready && busy < 100) begin
      k = an_index(0);
      if (k < 0 || seg_a !== exp_seg(5678, k, 1'b1)) bad++;
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 14) begin errors++; $display("FAIL b2b_second_busy got %0d expected 14", busy); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_hold_5678 bad samples %0d expected 0", bad); end
    checks++;
    if (a_if.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b expected 1", a_if.done); end
    check_display(42, 0, "b2b_42");
  endtask

  task automatic test_mid_reset();
    int dcount;
    wait_ready(0);
    drive(0, 8888, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (seg_a !== 7'b1111111) begin errors++; $display("FAIL midrst_seg got %b expected 1111111", seg_a); end
    checks++;
    if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", a_if.in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.done) dcount++;
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL midrst_done pulses %0d expected 0", dcount); end
    check_display(0, 0, "midrst_zero");
    check_conv(55, 0, "midrst_55");
  endtask

  initial begin
    glyphs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    test_reset();
    test_conversion();
    test_leading_zeros();
    test_boundary();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine.
- Drives a multiplexed 4-digit common-anode 7-segment display by time-sharing one instance of the existing `bcd` decoder across all digits.
- Sits between the processor's memory-mapped output register and the board's segment and anode pins.

Parameters:
- WIDTH, 14, input value width; must satisfy 2**WIDTH-1 >= MAX_VALUE.
- DIGITS, 4, number of scanned digits; MAX_VALUE = 10**DIGITS-1.
- SCAN_DIV, 50000, clocks per digit slot (1 kHz digit rate at 50 MHz).
- LZ_BLANK, 1, 1 = suppress leading zeros.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_value, input, WIDTH, unsigned binary value to display.
- in_valid, input, 1, in_value is valid.
- in_ready, output, 1, controller can accept a value.
- done, output, 1, one-cycle pulse when the new digits take effect.
- seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
- an, output, DIGITS, active-low one-hot digit enables; bit 0 is the rightmost digit.

Behaviour:
- Reset values, applied asynchronously while reset_n=0:
  - FSM in IDLE, prescaler 0, scan index 0.
  - All digit registers hold code 0.
  - in_ready=1, done=0, seg=7'b1111111, an=all ones.
- Reset mid-conversion aborts the conversion; the captured value is discarded.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready at an edge E0) loads the shift register with in_value and BCD nibbles=0, clears the iteration count, sets the overflow flag = (in_value > MAX_VALUE), and moves to CONV.
  - CONV: in_ready=0. On each edge, every nibble >=5 gets +3, then {bcd,shift} shifts left 1. After WIDTH iterations (edge E_WIDTH):
    - digit registers load the nibbles, or CODE_DASH on all digits if the overflow flag is set;
    - done=1 for the following cycle;
    - state returns to IDLE.
- Latency: handshake edge to display-register update = WIDTH edges. in_ready is high again in the cycle after E_WIDTH.
- A value may be accepted in the same cycle that done=1, giving back-to-back conversions.
- in_valid while in_ready=0 is ignored; the source must hold its value. The controller never drops an accepted value.
- Internal digit codes: 0-9 are decimal digits, 4'hA=CODE_BLANK, 4'hB=CODE_DASH.
- Only codes 0-9 reach the decoder, zero-extended to its 5-bit input. Blank and dash bypass the decoder as SEG_BLANK and SEG_DASH. The decoder's X default is therefore unreachable.
- Leading-zero blanking (LZ_BLANK=1): digit k>0 shows blank if it and all higher digits are 0. Digit 0 always shows.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On each wrap the scan index increments modulo DIGITS.
  - seg and an are registered together from the index, so they update on the same edge with no ghosting.
  - After reset the first valid seg/an pair appears on the first clock edge, showing digit 0 = "0".
- Digit registers change only at E_WIDTH; the scan always shows a coherent value, never a partial conversion.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111;
  - CODE_BLANK, CODE_DASH;
  - FSM state encoding (IDLE, CONV);
  - iteration-counter width function clog2.
- Sub-modules:
  - one instance of the existing `bcd` decoder, the shared resource;
  - optional `double_dabble_step`, a combinational add-3-and-shift for one iteration.
- Scan prescaler and FSM stay in the top module.

Test Plan:
- Reset: hold reset_n=0, SCAN_DIV=4 -> seg=7'b1111111, an=4'b1111, in_ready=1. Release -> first edge an=4'b1110, seg=7'b1000000 ("0"); digits 1-3 show blank.
- Conversion: send 1234 -> in_ready low for 14 cycles, done pulse at cycle 15. Scan shows an=1110/seg=0011001 ("4"), 1101/0110000, 1011/0100100, 0111/1111001.
- Leading zeros: send 7 -> digits 3..1 = 7'b1111111, digit 0 = 7'b1111000. Send 0 -> only digit 0 shows "0". With LZ_BLANK=0, sending 7 -> "0007".
- Overflow/boundary: send 9999 -> all digits 7'b0011000. Send 10000 and 16383 -> all digits 7'b0111111. No X ever appears on seg.
- Handshake: hold in_valid with 42 during CONV -> not accepted until in_ready=1. Accepting 42 in the done cycle gives back-to-back conversion; 5678 is shown, then 42.
- Mid-conversion reset: assert reset_n=0 at iteration 7 of converting 8888 -> display returns to "0", done never pulses, and a subsequent 55 converts correctly.
